// File: rtl/tnoc_flit_route_selector_pkg.sv
// Shared types for the flit route selector: NoC config, flit/header layout, route encoding.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package tnoc_flit_route_selector_pkg;

  localparam int TNOC_ID_WIDTH   = 8;
  localparam int TNOC_DATA_WIDTH = 32;

  // NoC configuration; only the VC count matters to the route selector.
  typedef struct packed {
    int virtual_channels;
  } tnoc_config;

  localparam tnoc_config TNOC_DEFAULT_CONFIG = '{virtual_channels: 2};

  typedef struct packed {
    logic [TNOC_ID_WIDTH-1:0] destination_id;
    logic [TNOC_ID_WIDTH-1:0] source_id;
  } tnoc_header;

  typedef struct packed {
    logic                       head;
    logic                       tail;
    tnoc_header                 header;
    logic [TNOC_DATA_WIDTH-1:0] data;
  } tnoc_flit;

  // Two demux outputs: local ejection and forward.
  localparam int TNOC_ROUTE_ENTRIES = 2;
  typedef logic [TNOC_ROUTE_ENTRIES-1:0] tnoc_route_index;

  localparam logic ROUTE_LOCAL   = 1'b0;
  localparam logic ROUTE_FORWARD = 1'b1;

  // Binary route number to one-hot demux select.
  function automatic tnoc_route_index route_onehot(input logic route);
    tnoc_route_index sel;
    sel        = '0;
    sel[route] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/tnoc_flit_if.sv
// Flit stream interface: per-VC valid/ready/vc_available plus one shared flit bus.
// Latency: n/a (wiring only).
// Backpressure: ready per VC from target; vc_available flows target -> initiator.
interface tnoc_flit_if
  import tnoc_flit_route_selector_pkg::*;
#(
  parameter int CHANNELS = 2
);
  logic [CHANNELS-1:0] valid;
  logic [CHANNELS-1:0] ready;
  logic [CHANNELS-1:0] vc_available;
  tnoc_flit            flit;

  modport initiator (output valid, input ready, output flit, input vc_available);
  modport target    (input valid, output ready, input flit, output vc_available);
endinterface

// File: rtl/tnoc_flit_route_selector_route_table.sv
// Per-VC packet route memory: latches route on head, holds it through tail.
// Latency: lookup is combinational; update takes effect the cycle after acceptance.
// Backpressure: none; caller qualifies i_update with its own handshake.
module tnoc_route_table
  import tnoc_flit_route_selector_pkg::*;
#(
  parameter int CHANNELS = 2
)(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_update,
  input  logic [CHANNELS-1:0] i_vc,
  input  logic                i_head,
  input  logic                i_tail,
  input  logic                i_head_route,
  output logic                o_route,
  output logic                o_miss
);

  logic [CHANNELS-1:0] r_open;
  logic [CHANNELS-1:0] r_route;
  logic                w_open;
  logic                w_route;

  // i_vc is one-hot, so an OR-reduce picks the addressed VC's entry.
  assign w_open  = |(r_open & i_vc);
  assign w_route = |(r_route & i_vc);

  // Route for the presented flit: heads decode fresh, bodies reuse the table,
  // orphan bodies fall back to local ejection and report a miss.
  always_comb begin
    o_route = ROUTE_LOCAL;
    o_miss  = 1'b0;
    if (i_head) begin
      o_route = i_head_route;
    end else if (w_open) begin
      o_route = w_route;
    end else begin
      o_miss = 1'b1;
    end
  end

  // Open on head (unless it is also the tail), close on tail; a head on an
  // already-open VC simply overwrites the stale route.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_open  <= '0;
      r_route <= '0;
    end else if (i_update) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (i_vc[c]) begin
          if (i_head) begin
            r_route[c] <= i_head_route;
          end
          if (i_head || i_tail) begin
            r_open[c] <= i_head && !i_tail;
          end
        end
      end
    end
  end

endmodule

// File: rtl/tnoc_flit_route_selector.sv
// Registered slice in front of the flit demux that produces its one-hot select per packet.
// Latency: 1 cycle accept -> output valid; sustains 1 flit/cycle.
// Backpressure: ready on all VCs = slot empty or slot draining this cycle; vc_available passes through.
module tnoc_flit_route_selector
  import tnoc_flit_route_selector_pkg::*;
#(
  parameter tnoc_config               CONFIG   = TNOC_DEFAULT_CONFIG,
  parameter int                       CHANNELS = CONFIG.virtual_channels,
  parameter int                       ENTRIES  = 2,
  parameter logic [TNOC_ID_WIDTH-1:0] LOCAL_ID = '0
)(
  input  logic               i_clk,
  input  logic               i_rst_n,
  tnoc_flit_if.target        flit_in_if,
  tnoc_flit_if.initiator     flit_out_if,
  output logic [ENTRIES-1:0] o_select,
  output logic               o_route_error
);

  if (ENTRIES != TNOC_ROUTE_ENTRIES) begin : g_entries_check
    $fatal(1, "tnoc_flit_route_selector: ENTRIES must be 2");
  end

  logic [CHANNELS-1:0] r_valid;
  tnoc_flit            r_flit;
  tnoc_route_index     r_select;
  logic                r_route_error;

  logic w_drain;
  logic w_ready;
  logic w_accept;
  logic w_head_route;
  logic w_route;
  logic w_miss;

  // Slot empties when its occupied VC is accepted downstream, which frees
  // room for a new flit in the same cycle.
  assign w_drain  = |(r_valid & flit_out_if.ready);
  assign w_ready  = (r_valid == '0) || w_drain;
  assign w_accept = w_ready && (flit_in_if.valid != '0);

  assign w_head_route = (flit_in_if.flit.header.destination_id == LOCAL_ID) ? ROUTE_LOCAL
                                                                             : ROUTE_FORWARD;

  assign flit_in_if.ready        = {CHANNELS{w_ready}};
  assign flit_in_if.vc_available = flit_out_if.vc_available;

  assign flit_out_if.valid = r_valid;
  assign flit_out_if.flit  = r_flit;
  assign o_select          = r_select;
  assign o_route_error     = r_route_error;

  tnoc_route_table #(
    .CHANNELS (CHANNELS)
  ) u_route_table (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_update     (w_accept),
    .i_vc         (flit_in_if.valid),
    .i_head       (flit_in_if.flit.head),
    .i_tail       (flit_in_if.flit.tail),
    .i_head_route (w_head_route),
    .o_route      (w_route),
    .o_miss       (w_miss)
  );

  // Slot control: load on accept, go empty on a drain with no refill.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid       <= '0;
      r_select      <= route_onehot(ROUTE_LOCAL);
      r_route_error <= 1'b0;
    end else begin
      r_route_error <= w_accept && w_miss;
      if (w_accept) begin
        r_valid  <= flit_in_if.valid;
        r_select <= route_onehot(w_route);
      end else if (w_drain) begin
        r_valid <= '0;
      end
    end
  end

  // Flit payload needs no reset; it is only observed while r_valid is set.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_flit <= flit_in_if.flit;
    end
  end

  a_single_valid_vc: assert property (
    @(posedge i_clk) disable iff (!i_rst_n) $onehot0(flit_in_if.valid)
  );

  a_hold_while_stalled: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    ((r_valid != '0) && !w_drain) |=> ($stable(r_flit) && $stable(r_select))
  );

endmodule

// File: doc/tnoc_flit_route_selector.md
Name: tnoc_flit_route_selector

Overview:
- Single-stage registered slice that sits directly upstream of the flit demux and generates its one-hot select.
- Decodes the destination of each head flit and latches the route per virtual channel.
- Steers every following flit of that packet, through its tail, to the same entry.
- Entry 0 is local ejection (destination equals LOCAL_ID); entry 1 is forward.

Parameters:
- CONFIG, TNOC_DEFAULT_CONFIG, NoC configuration (flit format, id widths, virtual_channels).
- CHANNELS, CONFIG.virtual_channels, number of virtual channels.
- ENTRIES, 2, number of demux outputs. Fixed at 2; any other value is an elaboration error.
- LOCAL_ID, 0, destination id of this node, compared against the header destination_id.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  synchronous active-low reset.
- flit_in_if  tnoc_flit_if.target  -  upstream flit stream; valid/ready/vc_available are CHANNELS wide.
- flit_out_if  tnoc_flit_if.initiator  -  registered flit stream to the demux.
- o_select  output  ENTRIES  one-hot select for the demux; describes the flit currently presented on flit_out_if.
- o_route_error  output  1  one-cycle pulse when a non-head flit arrives on a VC with no open packet.

Behaviour:
- Reset: one clock, synchronous, active-low (i_rst_n sampled on i_clk).
  - flit_out_if.valid = 0.
  - o_select = 'b01.
  - o_route_error = 0.
  - All per-VC route registers cleared to closed, route 0.
  - Stored flit is don't-care.
- Reset mid-packet discards the stored flit and all open routes. A following non-head flit raises o_route_error.
- Storage: one slot holding the flit, a CHANNELS-wide valid vector (at most one bit set), and the select.
- Acceptance:
  - flit_in_if.ready[c] = !slot_valid || (slot_valid[c'] && flit_out_if.ready[c']), where c' is the occupied channel.
  - The same value is driven on all channels (full-throughput pipeline).
  - A flit is accepted when flit_in_if.valid[c] && flit_in_if.ready[c].
- Latency: one cycle from input accept to flit_out_if.valid. Back-to-back throughput: 1 flit/cycle.
- Simultaneous drain and fill in the same cycle is legal; the slot is reloaded with no bubble.
- Route decode on a head-flit accept on VC c:
  - route = (destination_id == LOCAL_ID) ? 0 : 1.
  - route_reg[c] = route; open[c] = 1.
  - Slot select = onehot(route).
- Non-head flit on VC c with open[c] = 1: slot select = onehot(route_reg[c]).
- Tail flit (tail bit set, including single-flit head+tail) clears open[c] after acceptance.
- Non-head flit on VC c with open[c] = 0:
  - Flit is still accepted and forwarded with select onehot(0).
  - o_route_error pulses high the cycle after acceptance.
- Head flit on a VC with open[c] = 1 (missing tail): the new head overwrites route_reg[c]. No error.
- Interleaving: packets on different VCs may interleave flit-by-flit. Each VC keeps its own route_reg/open.
- o_select and flit_out_if.flit are stable while flit_out_if.valid is high and not accepted.
- flit_in_if.vc_available is driven combinationally from flit_out_if.vc_available, unregistered.
- Upstream must present at most one valid channel per cycle. Violation is flagged by an assertion only.

Decomposition:
- Shared package: route_index typedef (ENTRIES-bit one-hot), ROUTE_LOCAL = 0, ROUTE_FORWARD = 1. Flit and header typedefs come from the existing packet/flit includes.
- One natural sub-module: tnoc_route_table. It holds per-VC route_reg/open and its update/lookup, keeping the slot logic in the top.

Test Plan:
- After reset: o_select = 'b01, flit_out_if.valid = 0, flit_in_if.ready all 1.
- LOCAL_ID = 5; head (dest = 5) + payload + tail on VC0, downstream always ready → three output flits, each one cycle later, o_select = 'b01 on all three, open[0] cleared after tail.
- Head (dest = 3) on VC0 and head (dest = 5) on VC1, flits alternating VC0/VC1 → o_select alternates 'b10/'b01 per flit and matches each VC's packet through both tails.
- Downstream ready = 0 for 4 cycles with the slot full → flit_in_if.ready = 0, output flit and o_select held constant. On ready = 1, next flit accepted the same cycle with no bubble.
- Payload on VC0 with no open packet → forwarded with o_select = 'b01, o_route_error = 1 for exactly one cycle.
- Reset asserted after a head (dest = 3) on VC0, then payload on VC0 → o_route_error pulses, o_select = 'b01.
